hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the five-stage core.
- Tracks destination register and remaining-latency (Tnew) for instructions in E, M and W.
- Compares them against D/E/M-stage source operands to produce:
  - the 2-bit selects that drive the 3-input 32-bit operand muxes (0 = original value, 1 = M-stage result, 2 = W-stage result);
  - a single stall request for the F/D registers.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_ctrl_fwd_pick.sv | 27 ++
 rtl/hazard_ctrl.sv | 79 +++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and shadow-record types for the pipeline hazard controller.
package hazard_pkg;

  localparam int HZ_REG_AW = 5;
  localparam int HZ_TW     = 2;

  localparam logic [1:0] SEL_ORIG  = 2'd0;
  localparam logic [1:0] SEL_M     = 2'd1;
  localparam logic [1:0] SEL_W     = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_MAX  = 2'd2;

  typedef struct packed {
    logic [HZ_REG_AW-1:0] a3;
    logic [HZ_TW-1:0]     tnew;
    logic [HZ_REG_AW-1:0] rs;
    logic [HZ_REG_AW-1:0] rt;
  } e_rec_t;

  typedef struct packed {
    logic [HZ_REG_AW-1:0] a3;
    logic [HZ_TW-1:0]     tnew;
    logic [HZ_REG_AW-1:0] rt;
  } m_rec_t;

  // Decrement that sticks at zero instead of wrapping.
  function automatic logic [HZ_TW-1:0] dec_sat0(input logic [HZ_TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_pick.sv
// Forward-select for one operand: newest ready producer wins (M over W), $0 never forwards.
module fwd_pick
  import hazard_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW,
  parameter int TW     = HZ_TW
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_m_a3,
  input  logic [TW-1:0]     i_m_tnew,
  input  logic [REG_AW-1:0] i_w_a3,
  output logic [1:0]        o_sel
);

  logic w_src_nz;
  assign w_src_nz = (i_src != '0);

  always_comb begin
    o_sel = SEL_ORIG;
    if (w_src_nz && (i_src == i_m_a3) && (i_m_tnew == '0)) begin
      o_sel = SEL_M;
    end else if (w_src_nz && (i_src == i_w_a3)) begin
      o_sel = SEL_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadows dest/Tnew of E, M, W and derives the F/D stall
// plus operand-mux forward selects combinationally from those records and D inputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW,
  parameter int TW     = HZ_TW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [TW-1:0]     d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic [1:0]        fwd_rt_m
);

  e_rec_t            r_e;
  m_rec_t            r_m;
  logic [REG_AW-1:0] r_w_a3;

  logic w_hz_rs;
  logic w_hz_rt;

  // A producer still needing more cycles than the reader can wait forces a stall.
  assign w_hz_rs = (d_rs != '0) &&
                   (((d_rs == r_e.a3) && (r_e.tnew > d_tuse_rs)) ||
                    ((d_rs == r_m.a3) && (r_m.tnew > d_tuse_rs)));
  assign w_hz_rt = (d_rt != '0) &&
                   (((d_rt == r_e.a3) && (r_e.tnew > d_tuse_rt)) ||
                    ((d_rt == r_m.a3) && (r_m.tnew > d_tuse_rt)));
  assign stall   = w_hz_rs || w_hz_rt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e    <= '0;
      r_m    <= '0;
      r_w_a3 <= '0;
    end else begin
      r_w_a3    <= r_m.a3;
      r_m.a3    <= r_e.a3;
      r_m.tnew  <= dec_sat0(r_e.tnew);
      r_m.rt    <= r_e.rt;
      if (stall) begin
        r_e <= '0;
      end else begin
        r_e.a3   <= d_a3;
        r_e.tnew <= d_tnew;
        r_e.rs   <= d_rs;
        r_e.rt   <= d_rt;
      end
    end
  end

  fwd_pick #(.REG_AW(REG_AW), .TW(TW)) u_pick_rs_d (
    .i_src(d_rs), .i_m_a3(r_m.a3), .i_m_tnew(r_m.tnew), .i_w_a3(r_w_a3), .o_sel(fwd_rs_d)
  );
  fwd_pick #(.REG_AW(REG_AW), .TW(TW)) u_pick_rt_d (
    .i_src(d_rt), .i_m_a3(r_m.a3), .i_m_tnew(r_m.tnew), .i_w_a3(r_w_a3), .o_sel(fwd_rt_d)
  );
  fwd_pick #(.REG_AW(REG_AW), .TW(TW)) u_pick_rs_e (
    .i_src(r_e.rs), .i_m_a3(r_m.a3), .i_m_tnew(r_m.tnew), .i_w_a3(r_w_a3), .o_sel(fwd_rs_e)
  );
  fwd_pick #(.REG_AW(REG_AW), .TW(TW)) u_pick_rt_e (
    .i_src(r_e.rt), .i_m_a3(r_m.a3), .i_m_tnew(r_m.tnew), .i_w_a3(r_w_a3), .o_sel(fwd_rt_e)
  );
  // Store data in M can only be fed from W, so the M-side match is tied off.
  fwd_pick #(.REG_AW(REG_AW), .TW(TW)) u_pick_rt_m (
    .i_src(r_m.rt), .i_m_a3('0), .i_m_tnew(r_m.tnew), .i_w_a3(r_w_a3), .o_sel(fwd_rt_m)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: reference pipeline history predicts each cycle's outputs.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_a3(d_a3), .d_tnew(d_tnew),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } ins_t;

  // hist[0] sits in E, hist[1] in M, hist[2] in W; tnew kept as issued from D.
  ins_t        hist [3];
  logic [10:0] exp_q [$];
  logic [10:0] obs;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [1:0] pick(input logic [4:0] s, input logic [4:0] ma,
                                      input logic [1:0] mt, input logic [4:0] wa);
    if (s == 5'd0)              return 2'd0;
    if (s == ma && mt == 2'd0)  return 2'd1;
    if (s == wa)                return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] age_tnew(input logic [1:0] t, input int age);
    return (int'(t) > age) ? 2'(int'(t) - age) : 2'd0;
  endfunction

  function automatic logic waits(input logic [4:0] s, input logic [1:0] tuse);
    logic w;
    w = 1'b0;
    for (int k = 0; k < 2; k++)
      if (s != 5'd0 && s == hist[k].a3 && age_tnew(hist[k].tnew, k) > tuse) w = 1'b1;
    return w;
  endfunction

  function automatic logic [10:0] predict(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [1:0] tur, input logic [1:0] tut);
    logic [1:0] mt;
    logic [1:0] rtm;
    mt  = age_tnew(hist[1].tnew, 1);
    rtm = (hist[1].rt != 5'd0 && hist[1].rt == hist[2].a3) ? 2'd2 : 2'd0;
    return {waits(rs, tur) | waits(rt, tut),
            pick(rs, hist[1].a3, mt, hist[2].a3),
            pick(rt, hist[1].a3, mt, hist[2].a3),
            pick(hist[0].rs, hist[1].a3, mt, hist[2].a3),
            pick(hist[0].rt, hist[1].a3, mt, hist[2].a3),
            rtm};
  endfunction

  task automatic cyc(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] tur, input logic [1:0] tut,
                     input logic [4:0] a3, input logic [1:0] tn);
    logic [10:0] e;
    logic [10:0] w;
    reset = rst; d_rs = rs; d_rt = rt; d_tuse_rs = tur; d_tuse_rt = tut;
    d_a3 = a3; d_tnew = tn;
    e = predict(rs, rt, tur, tut);
    if (!rst) exp_q.push_back(e);
    @(negedge clk);
    obs = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
    if (!rst && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("stall",    32'(obs[10]),   32'(w[10]));
      chk("fwd_rs_d", 32'(obs[9:8]),  32'(w[9:8]));
      chk("fwd_rt_d", 32'(obs[7:6]),  32'(w[7:6]));
      chk("fwd_rs_e", 32'(obs[5:4]),  32'(w[5:4]));
      chk("fwd_rt_e", 32'(obs[3:2]),  32'(w[3:2]));
      chk("fwd_rt_m", 32'(obs[1:0]),  32'(w[1:0]));
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e[10] ? ins_t'('0) : ins_t'({a3, tn, rs, rt});
    end
    #1;
  endtask

  task automatic nop();
    cyc(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
  endtask

  int   n;
  logic s_acc;

  initial begin
    reset = 1'b1; d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_a3 = '0; d_tnew = '0;
    #1;

    // Reset with a would-be hazard sitting on D
    cyc(1'b1, 5'd5, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2);
    cyc(1'b1, 5'd5, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2);
    cyc(1'b0, 5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd2);
    chk("rst_stall", 32'(obs[10]), 0);
    chk("rst_sel",   32'(obs[9:0]), 0);
    nop(); nop(); nop();

    // Load-use: two stall cycles, then W forward into D
    cyc(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2);
    n = 0;
    do begin
      cyc(1'b0, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
      if (obs[10]) n++;
    end while (obs[10] && n < 6);
    chk("ldu_stall_cycles", n, 2);
    chk("ldu_fwd_rs_d", 32'(obs[9:8]), 2);
    nop(); nop(); nop();

    // ALU chain: no stall, M then W forward into E
    cyc(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1);
    cyc(1'b0, 5'd0, 5'd9, 2'd3, 2'd1, 5'd0, 2'd0);
    chk("alu_stall", 32'(obs[10]), 0);
    cyc(1'b0, 5'd0, 5'd9, 2'd3, 2'd1, 5'd0, 2'd0);
    chk("alu_fwd_rt_e_m", 32'(obs[3:2]), 1);
    nop();
    chk("alu_fwd_rt_e_w", 32'(obs[3:2]), 2);
    nop(); nop();

    // Two writers of $10: the newer one in M must win
    cyc(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1);
    cyc(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1);
    n = 0;
    do begin
      cyc(1'b0, 5'd10, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
      n++;
    end while (obs[10] && n < 6);
    chk("dbl_fwd_rs_d", 32'(obs[9:8]), 1);
    nop(); nop(); nop();

    // $0 never hazards
    cyc(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
      chk("zero_stall",    32'(obs[10]),  0);
      chk("zero_fwd_rs_d", 32'(obs[9:8]), 0);
    end
    nop(); nop();

    // Store data forwarded from W into M
    cyc(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd12, 2'd1);
    cyc(1'b0, 5'd0, 5'd12, 2'd3, 2'd2, 5'd0, 2'd0);
    s_acc = obs[10];
    nop();
    s_acc = s_acc | obs[10];
    nop();
    s_acc = s_acc | obs[10];
    chk("st_fwd_rt_m", 32'(obs[1:0]), 2);
    chk("st_stall", 32'(s_acc), 0);
    nop(); nop();

    // Reset mid-flight drops the pending load
    cyc(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2);
    cyc(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
    cyc(1'b0, 5'd7, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
    chk("midrst_stall", 32'(obs[10]), 0);
    nop(); nop();

    // Random traffic on a small register set to provoke overlaps
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
